hdmi_video_timing_out: RTL and testbench

Pixel-output stage of the HDMI card. It sits directly downstream of the 64-in/16-out prefetch FIFO in the `rd_clk` (pixel clock) domain. It generates the video raster (hs/vs/de) and pops one 16-bit RGB565 word from the FIFO per active pixel. It expands each word to RGB888 for the HDMI encoder and reports FIFO underflow.

---
 rtl/hdmi_video_timing_out.sv | 218 +++++++++++++++++++++
 tb/tb_hdmi_video_timing_out.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_video_timing_out.sv
// -----------------------------------------------------------------------------
// HdmiVideoTimingOut : pixel-output stage of the HDMI card.
//
// Produces the video raster (hsync / vsync / data-enable) in the pixel-clock
// domain. During every active pixel it pops one RGB565 word from the
// first-word-fall-through prefetch FIFO and expands it to RGB888 for the
// HDMI encoder. An active pixel that finds the FIFO empty is counted as an
// underflow. Raster timing is never stalled.
//
// Ports
//   rd_clk         in   pixel clock, rising edge
//   rd_rst         in   asynchronous active-high reset
//   en             in   video enable (level)
//   fifo_rd_data   in   [15:0] RGB565 word {R5,G6,B5}, FWFT
//   fifo_rd_vld    in   fifo_rd_data is valid
//   fifo_rd_en     out  pop request (word consumed when fifo_rd_en & fifo_rd_vld)
//   frame_sync     out  one-cycle pulse at the start of vertical blanking
//   underflow_clr  in   clears the underflow flag and counter
//   underflow      out  sticky underflow flag
//   underflow_cnt  out  [15:0] saturating count of missed pixels
//   vid_hs/vs/de   out  registered sync and data-enable
//   vid_rgb        out  [23:0] registered RGB888 {R8,G8,B8}
// -----------------------------------------------------------------------------
module hdmi_video_timing_out #(
    parameter int   H_ACTIVE = 1280,
    parameter int   H_FP     = 110,
    parameter int   H_SYNC   = 40,
    parameter int   H_BP     = 220,
    parameter int   V_ACTIVE = 720,
    parameter int   V_FP     = 5,
    parameter int   V_SYNC   = 5,
    parameter int   V_BP     = 20,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1
) (
    input  logic        rd_clk,
    input  logic        rd_rst,
    input  logic        en,
    input  logic [15:0] fifo_rd_data,
    input  logic        fifo_rd_vld,
    output logic        fifo_rd_en,
    output logic        frame_sync,
    input  logic        underflow_clr,
    output logic        underflow,
    output logic [15:0] underflow_cnt,
    output logic        vid_hs,
    output logic        vid_vs,
    output logic        vid_de,
    output logic [23:0] vid_rgb
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RUN
    } state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   hCnt_q, hCnt_d;
    logic [VW-1:0]   vCnt_q, vCnt_d;
    logic            stop_q, stop_d;

    logic            vidDe_q;
    logic            vidHs_q;
    logic            vidVs_q;
    logic [23:0]     vidRgb_q;
    logic            underflow_q;
    logic [15:0]     underflowCnt_q;

    logic            isRun;
    logic            hLast;
    logic            vLast;
    logic            stopReq;
    logic            dePre;
    logic            hsPre;
    logic            vsPre;
    logic            missPix;
    logic [23:0]     rgbExp;

    // Raster decode. Everything here depends only on registered state and
    // counters, so the FIFO handshake has no combinational loop through
    // fifo_rd_vld.
    assign isRun   = (state_q == S_RUN);
    assign hLast   = (int'(hCnt_q) == H_TOTAL - 1);
    assign vLast   = (int'(vCnt_q) == V_TOTAL - 1);
    assign stopReq = stop_q | ~en;
    assign dePre   = isRun && (int'(hCnt_q) < H_ACTIVE) && (int'(vCnt_q) < V_ACTIVE);
    assign hsPre   = isRun && (int'(hCnt_q) >= HS_START) && (int'(hCnt_q) < HS_END);
    assign vsPre   = isRun && (int'(vCnt_q) >= VS_START) && (int'(vCnt_q) < VS_END);
    assign missPix = dePre & ~fifo_rd_vld;

    // Bit replication fills the low bits so full-scale 565 maps to 0xFF.
    assign rgbExp = {fifo_rd_data[15:11], fifo_rd_data[15:13],
                     fifo_rd_data[10:5],  fifo_rd_data[10:9],
                     fifo_rd_data[4:0],   fifo_rd_data[4:2]};

    assign fifo_rd_en = dePre;
    assign frame_sync = isRun && (hCnt_q == '0) && (int'(vCnt_q) == V_ACTIVE);

    // State, raster counters and stop latch. A stop request in RUN is only
    // honoured after the last pixel of the frame so the sink never sees a
    // truncated frame.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_q <= S_IDLE;
            hCnt_q  <= '0;
            vCnt_q  <= '0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hCnt_q  <= hCnt_d;
            vCnt_q  <= vCnt_d;
            stop_q  <= stop_d;
        end
    end

    // Next-state logic. Outside RUN the counters are parked at 0 so the
    // first RUN cycle is always the first pixel of a frame.
    always_comb begin
        state_d = state_q;
        hCnt_d  = hCnt_q;
        vCnt_d  = vCnt_q;
        stop_d  = stop_q;
        case (state_q)
            S_IDLE: begin
                hCnt_d = '0;
                vCnt_d = '0;
                stop_d = 1'b0;
                if (en) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                hCnt_d = '0;
                vCnt_d = '0;
                stop_d = 1'b0;
                if (!en) begin
                    state_d = S_IDLE;
                end else if (fifo_rd_vld) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                stop_d = stopReq;
                if (hLast) begin
                    hCnt_d = '0;
                    if (vLast) begin
                        vCnt_d = '0;
                        if (stopReq) begin
                            state_d = S_IDLE;
                            stop_d  = 1'b0;
                        end
                    end else begin
                        vCnt_d = vCnt_q + VW'(1);
                    end
                end else begin
                    hCnt_d = hCnt_q + HW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                hCnt_d  = '0;
                vCnt_d  = '0;
                stop_d  = 1'b0;
            end
        endcase
    end

    // Output register stage: one cycle behind the counters. A missed pixel
    // is sent as black rather than repeating stale data.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            vidDe_q  <= 1'b0;
            vidHs_q  <= ~HS_POL;
            vidVs_q  <= ~VS_POL;
            vidRgb_q <= '0;
        end else begin
            vidDe_q  <= dePre;
            vidHs_q  <= hsPre ? HS_POL : ~HS_POL;
            vidVs_q  <= vsPre ? VS_POL : ~VS_POL;
            vidRgb_q <= (dePre && fifo_rd_vld) ? rgbExp : 24'h000000;
        end
    end

    // Underflow bookkeeping. A clear wins over an event in the same cycle.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            underflow_q    <= 1'b0;
            underflowCnt_q <= '0;
        end else if (underflow_clr) begin
            underflow_q    <= 1'b0;
            underflowCnt_q <= '0;
        end else if (missPix) begin
            underflow_q <= 1'b1;
            if (underflowCnt_q != 16'hFFFF) begin
                underflowCnt_q <= underflowCnt_q + 16'd1;
            end
        end
    end

    assign vid_de        = vidDe_q;
    assign vid_hs        = vidHs_q;
    assign vid_vs        = vidVs_q;
    assign vid_rgb       = vidRgb_q;
    assign underflow     = underflow_q;
    assign underflow_cnt = underflowCnt_q;

endmodule

// File: tb/tb_hdmi_video_timing_out.sv
// -----------------------------------------------------------------------------
// Self-checking bench for hdmi_video_timing_out with a tiny raster:
// 8 clocks per line (4 active, FP 1, sync 2, BP 1) and 5 lines per frame
// (2 active, FP 1, sync 1, BP 1), giving a 40-cycle frame.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_hdmi_video_timing_out;

    localparam int HT    = 8;
    localparam int FRAME = 40;

    logic        rd_clk = 1'b0;
    logic        rd_rst;
    logic        en;
    logic [15:0] fifo_rd_data;
    logic        fifo_rd_vld;
    logic        fifo_rd_en;
    logic        frame_sync;
    logic        underflow_clr;
    logic        underflow;
    logic [15:0] underflow_cnt;
    logic        vid_hs;
    logic        vid_vs;
    logic        vid_de;
    logic [23:0] vid_rgb;

    int   checks   = 0;
    int   errors   = 0;
    int   popCount = 0;
    logic pendPop;

    always #5 rd_clk = ~rd_clk;

    hdmi_video_timing_out #(
        .H_ACTIVE (4),
        .H_FP     (1),
        .H_SYNC   (2),
        .H_BP     (1),
        .V_ACTIVE (2),
        .V_FP     (1),
        .V_SYNC   (1),
        .V_BP     (1),
        .HS_POL   (1'b1),
        .VS_POL   (1'b1)
    ) dut (
        .rd_clk        (rd_clk),
        .rd_rst        (rd_rst),
        .en            (en),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_vld   (fifo_rd_vld),
        .fifo_rd_en    (fifo_rd_en),
        .frame_sync    (frame_sync),
        .underflow_clr (underflow_clr),
        .underflow     (underflow),
        .underflow_cnt (underflow_cnt),
        .vid_hs        (vid_hs),
        .vid_vs        (vid_vs),
        .vid_de        (vid_de),
        .vid_rgb       (vid_rgb)
    );

    // Expected raster flags for frame position p (0..39).
    function automatic logic expDe(input int p);
        return ((p % HT) < 4) && ((p / HT) < 2);
    endfunction

    function automatic logic expHs(input int p);
        return ((p % HT) >= 5) && ((p % HT) < 7);
    endfunction

    function automatic logic expVs(input int p);
        return (p / HT) == 3;
    endfunction

    // RGB565 -> RGB888 by shifting up and filling with the top bits.
    function automatic logic [23:0] expand(input logic [15:0] w);
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        r = {3'b000, w[15:11]};
        g = {2'b00, w[10:5]};
        b = {3'b000, w[4:0]};
        r = (r << 3) | (r >> 2);
        g = (g << 2) | (g >> 4);
        b = (b << 3) | (b >> 2);
        return {r, g, b};
    endfunction

    // One clock: note whether a pop happens at the coming rising edge,
    // then return on the next falling edge.
    task automatic cycle();
        pendPop = fifo_rd_en && fifo_rd_vld;
        @(posedge rd_clk);
        @(negedge rd_clk);
        if (pendPop) popCount++;
    endtask

    task automatic doReset();
        rd_rst        = 1'b1;
        en            = 1'b0;
        fifo_rd_vld   = 1'b0;
        fifo_rd_data  = 16'h0000;
        underflow_clr = 1'b0;
        @(negedge rd_clk);
        @(negedge rd_clk);
        rd_rst   = 1'b0;
        popCount = 0;
    endtask

    // Reset values while reset is held, then idle behaviour after release.
    task automatic test_reset();
        rd_rst        = 1'b1;
        en            = 1'b0;
        fifo_rd_vld   = 1'b0;
        fifo_rd_data  = 16'h0000;
        underflow_clr = 1'b0;
        @(negedge rd_clk);
        @(negedge rd_clk);
        if (vid_de !== 1'b0) begin errors++; $display("[TB] FAIL reset_de: got %b want 0", vid_de); end
        checks++;
        if (vid_hs !== 1'b0) begin errors++; $display("[TB] FAIL reset_hs: got %b want 0", vid_hs); end
        checks++;
        if (vid_vs !== 1'b0) begin errors++; $display("[TB] FAIL reset_vs: got %b want 0", vid_vs); end
        checks++;
        if (vid_rgb !== 24'h000000) begin errors++; $display("[TB] FAIL reset_rgb: got %h want 000000", vid_rgb); end
        checks++;
        if (fifo_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
        checks++;
        if (frame_sync !== 1'b0) begin errors++; $display("[TB] FAIL reset_fsync: got %b want 0", frame_sync); end
        checks++;
        if (underflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_uf: got %b want 0", underflow); end
        checks++;
        if (underflow_cnt !== 16'h0000) begin errors++; $display("[TB] FAIL reset_ufcnt: got %h want 0000", underflow_cnt); end
        checks++;
        rd_rst = 1'b0;
        fifo_rd_vld = 1'b1;
        cycle();
        cycle();
        if (fifo_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL idle_rd_en: got %b want 0", fifo_rd_en); end
        checks++;
        if (vid_de !== 1'b0) begin errors++; $display("[TB] FAIL idle_de: got %b want 0", vid_de); end
        checks++;
    endtask

    // Two full frames with an always-valid FIFO carrying 0,1,2,...
    task automatic test_nominal();
        int            p;
        int            q;
        logic [15:0]   prevData;
        logic [23:0]   eRgb;
        doReset();
        en           = 1'b1;
        fifo_rd_vld  = 1'b1;
        fifo_rd_data = 16'h0000;
        cycle();
        if (fifo_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL nom_wait_rd_en: got %b want 0", fifo_rd_en); end
        checks++;
        cycle();
        prevData = 16'h0000;
        for (int k = 0; k < 2 * FRAME; k++) begin
            p = k % FRAME;
            q = (k + FRAME - 1) % FRAME;
            if (k == FRAME) begin
                if (popCount !== 8) begin errors++; $display("[TB] FAIL nom_pops_f0: got %0d want 8", popCount); end
                checks++;
            end
            if (fifo_rd_en !== expDe(p)) begin errors++; $display("[TB] FAIL nom_rd_en k=%0d: got %b want %b", k, fifo_rd_en, expDe(p)); end
            checks++;
            if (frame_sync !== (p == 16)) begin errors++; $display("[TB] FAIL nom_fsync k=%0d: got %b want %b", k, frame_sync, (p == 16)); end
            checks++;
            if (k > 0) begin
                eRgb = expDe(q) ? expand(prevData) : 24'h000000;
                if (vid_de !== expDe(q)) begin errors++; $display("[TB] FAIL nom_de k=%0d: got %b want %b", k, vid_de, expDe(q)); end
                checks++;
                if (vid_hs !== expHs(q)) begin errors++; $display("[TB] FAIL nom_hs k=%0d: got %b want %b", k, vid_hs, expHs(q)); end
                checks++;
                if (vid_vs !== expVs(q)) begin errors++; $display("[TB] FAIL nom_vs k=%0d: got %b want %b", k, vid_vs, expVs(q)); end
                checks++;
                if (vid_rgb !== eRgb) begin errors++; $display("[TB] FAIL nom_rgb k=%0d: got %h want %h", k, vid_rgb, eRgb); end
                checks++;
            end
            prevData = fifo_rd_data;
            cycle();
            fifo_rd_data = 16'(popCount);
        end
        if (popCount !== 16) begin errors++; $display("[TB] FAIL nom_pops_f1: got %0d want 16", popCount); end
        checks++;
    endtask

    // Primary colours and white through the 565 -> 888 expansion.
    task automatic test_colour();
        logic [15:0] words [4];
        logic [23:0] want  [4];
        words[0] = 16'hF800; want[0] = 24'hFF0000;
        words[1] = 16'h07E0; want[1] = 24'h00FF00;
        words[2] = 16'h001F; want[2] = 24'h0000FF;
        words[3] = 16'hFFFF; want[3] = 24'hFFFFFF;
        doReset();
        en           = 1'b1;
        fifo_rd_vld  = 1'b1;
        fifo_rd_data = words[0];
        cycle();
        cycle();
        for (int k = 0; k < 6; k++) begin
            if (k >= 1 && k <= 4) begin
                if (vid_de !== 1'b1) begin errors++; $display("[TB] FAIL col_de k=%0d: got %b want 1", k, vid_de); end
                checks++;
                if (vid_rgb !== want[k-1]) begin errors++; $display("[TB] FAIL col_rgb k=%0d: got %h want %h", k, vid_rgb, want[k-1]); end
                checks++;
            end
            cycle();
            fifo_rd_data = (popCount < 4) ? words[popCount] : 16'h0000;
        end
    endtask

    // One missed pixel on line 0, a plain clear, then a clear that collides
    // with a second miss on the first pixel of the next frame.
    task automatic test_underflow();
        int          p;
        int          q;
        logic [15:0] prevData;
        logic        prevVld;
        logic [23:0] eRgb;
        doReset();
        en           = 1'b1;
        fifo_rd_vld  = 1'b1;
        fifo_rd_data = 16'h8421;
        cycle();
        cycle();
        prevData = 16'h0000;
        prevVld  = 1'b0;
        for (int k = 0; k < 44; k++) begin
            p = k % FRAME;
            q = (k + FRAME - 1) % FRAME;
            fifo_rd_vld   = !(k == 2 || k == 40);
            underflow_clr = (k == 20 || k == 40);
            if (k > 0) begin
                eRgb = (expDe(q) && prevVld) ? expand(prevData) : 24'h000000;
                if (vid_de !== expDe(q)) begin errors++; $display("[TB] FAIL uf_de k=%0d: got %b want %b", k, vid_de, expDe(q)); end
                checks++;
                if (vid_hs !== expHs(q)) begin errors++; $display("[TB] FAIL uf_hs k=%0d: got %b want %b", k, vid_hs, expHs(q)); end
                checks++;
                if (vid_vs !== expVs(q)) begin errors++; $display("[TB] FAIL uf_vs k=%0d: got %b want %b", k, vid_vs, expVs(q)); end
                checks++;
                if (vid_rgb !== eRgb) begin errors++; $display("[TB] FAIL uf_rgb k=%0d: got %h want %h", k, vid_rgb, eRgb); end
                checks++;
            end
            if (fifo_rd_en !== expDe(p)) begin errors++; $display("[TB] FAIL uf_rd_en k=%0d: got %b want %b", k, fifo_rd_en, expDe(p)); end
            checks++;
            if (k == 2) begin
                if (underflow !== 1'b0) begin errors++; $display("[TB] FAIL uf_before: got %b want 0", underflow); end
                checks++;
            end
            if (k == 3 || k == 20) begin
                if (underflow !== 1'b1) begin errors++; $display("[TB] FAIL uf_flag k=%0d: got %b want 1", k, underflow); end
                checks++;
                if (underflow_cnt !== 16'd1) begin errors++; $display("[TB] FAIL uf_cnt k=%0d: got %0d want 1", k, underflow_cnt); end
                checks++;
            end
            if (k == 21 || k == 41) begin
                if (underflow !== 1'b0) begin errors++; $display("[TB] FAIL uf_clr_flag k=%0d: got %b want 0", k, underflow); end
                checks++;
                if (underflow_cnt !== 16'd0) begin errors++; $display("[TB] FAIL uf_clr_cnt k=%0d: got %0d want 0", k, underflow_cnt); end
                checks++;
            end
            if (k == FRAME) begin
                if (popCount !== 7) begin errors++; $display("[TB] FAIL uf_pops: got %0d want 7", popCount); end
                checks++;
            end
            prevData = fifo_rd_data;
            prevVld  = fifo_rd_vld;
            cycle();
            fifo_rd_data = 16'h8421 + 16'(popCount);
        end
        underflow_clr = 1'b0;
        fifo_rd_vld   = 1'b1;
    endtask

    // Enabled but empty FIFO: nothing happens until data shows up.
    task automatic test_wait_gating();
        doReset();
        en          = 1'b1;
        fifo_rd_vld = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (fifo_rd_en !== 1'b0 || vid_de !== 1'b0 || underflow !== 1'b0) begin
                errors++;
                $display("[TB] FAIL wait_quiet i=%0d: got rd_en=%b de=%b uf=%b want 0 0 0", i, fifo_rd_en, vid_de, underflow);
            end
            checks++;
        end
        fifo_rd_vld  = 1'b1;
        fifo_rd_data = 16'hFFFF;
        cycle();
        if (vid_de !== 1'b0) begin errors++; $display("[TB] FAIL wait_de_early: got %b want 0", vid_de); end
        checks++;
        if (fifo_rd_en !== 1'b1) begin errors++; $display("[TB] FAIL wait_run_rd_en: got %b want 1", fifo_rd_en); end
        checks++;
        cycle();
        if (vid_de !== 1'b1) begin errors++; $display("[TB] FAIL wait_first_de: got %b want 1", vid_de); end
        checks++;
        if (vid_rgb !== 24'hFFFFFF) begin errors++; $display("[TB] FAIL wait_first_rgb: got %h want ffffff", vid_rgb); end
        checks++;
    endtask

    // en dropped in the middle of line 1: the frame still runs to its end.
    task automatic test_stop();
        int syncs;
        logic eRd;
        logic eDe;
        doReset();
        en           = 1'b1;
        fifo_rd_vld  = 1'b1;
        fifo_rd_data = 16'h0000;
        cycle();
        cycle();
        syncs = 0;
        for (int k = 0; k < 60; k++) begin
            if (k == 10) en = 1'b0;
            eRd = (k < FRAME) ? expDe(k) : 1'b0;
            eDe = (k >= 1 && k <= FRAME) ? expDe(k - 1) : 1'b0;
            if (frame_sync === 1'b1) syncs++;
            if (fifo_rd_en !== eRd) begin errors++; $display("[TB] FAIL stop_rd_en k=%0d: got %b want %b", k, fifo_rd_en, eRd); end
            checks++;
            if (frame_sync !== (k == 16)) begin errors++; $display("[TB] FAIL stop_fsync k=%0d: got %b want %b", k, frame_sync, (k == 16)); end
            checks++;
            if (vid_de !== eDe) begin errors++; $display("[TB] FAIL stop_de k=%0d: got %b want %b", k, vid_de, eDe); end
            checks++;
            cycle();
            fifo_rd_data = 16'(popCount);
        end
        if (syncs !== 1) begin errors++; $display("[TB] FAIL stop_sync_count: got %0d want 1", syncs); end
        checks++;
        if (popCount !== 8) begin errors++; $display("[TB] FAIL stop_pops: got %0d want 8", popCount); end
        checks++;
    endtask

    // Reset asserted between clock edges while an active pixel is showing.
    task automatic test_async_reset();
        doReset();
        en           = 1'b1;
        fifo_rd_vld  = 1'b1;
        fifo_rd_data = 16'hFFFF;
        cycle();
        cycle();
        fifo_rd_vld = 1'b0;
        cycle();
        fifo_rd_vld = 1'b1;
        cycle();
        cycle();
        if (vid_de !== 1'b1 || vid_rgb !== 24'hFFFFFF || underflow_cnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL arst_pre: got de=%b rgb=%h cnt=%0d want 1 ffffff 1", vid_de, vid_rgb, underflow_cnt);
        end
        checks++;
        #2;
        rd_rst = 1'b1;
        #1;
        if (vid_de !== 1'b0) begin errors++; $display("[TB] FAIL arst_de: got %b want 0", vid_de); end
        checks++;
        if (vid_hs !== 1'b0 || vid_vs !== 1'b0) begin errors++; $display("[TB] FAIL arst_sync: got hs=%b vs=%b want 0 0", vid_hs, vid_vs); end
        checks++;
        if (vid_rgb !== 24'h000000) begin errors++; $display("[TB] FAIL arst_rgb: got %h want 000000", vid_rgb); end
        checks++;
        if (fifo_rd_en !== 1'b0 || frame_sync !== 1'b0) begin errors++; $display("[TB] FAIL arst_comb: got rd_en=%b fsync=%b want 0 0", fifo_rd_en, frame_sync); end
        checks++;
        if (underflow !== 1'b0 || underflow_cnt !== 16'd0) begin errors++; $display("[TB] FAIL arst_uf: got uf=%b cnt=%0d want 0 0", underflow, underflow_cnt); end
        checks++;
        @(negedge rd_clk);
        rd_rst = 1'b0;
        cycle();
        if (fifo_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL arst_restart_wait: got %b want 0", fifo_rd_en); end
        checks++;
        cycle();
        if (fifo_rd_en !== 1'b1) begin errors++; $display("[TB] FAIL arst_restart_run: got %b want 1", fifo_rd_en); end
        checks++;
    endtask

    initial begin
        rd_rst        = 1'b1;
        en            = 1'b0;
        fifo_rd_vld   = 1'b0;
        fifo_rd_data  = 16'h0000;
        underflow_clr = 1'b0;
        @(negedge rd_clk);
        test_reset();
        test_nominal();
        test_colour();
        test_underflow();
        test_wait_gating();
        test_stop();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
